// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: 2-flop input synchronizer, deframing FSM,
// small receive FIFO, DATA/STATUS registers read over a ce/r strobe.
`timescale 1ns/1ps
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       ce,
    input  logic       r,
    input  logic       addr,
    output logic [7:0] out_data,
    output logic       irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q, rxs_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push, set_ferr;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          ferr_q, ovr_q;
    logic          empty, full, pop, push_ok, ovr_set, rd_stat;
    logic [7:0]    status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
        end
    end

    // The shift register only carries payload; a reset-truncated byte is never pushed.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        bidx_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    if (bidx_q == 3'd7) state_d = S_STOP;
                    else                bidx_d  = bidx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign pop     = ce & r & ~addr & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;
    assign rd_stat = ce & r & addr;
    assign status  = {4'b0000, ferr_q, ovr_q, full, ~empty};

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            out_data <= 8'h00;
            irq      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ferr_q  <= set_ferr | (ferr_q & ~rd_stat);
            ovr_q   <= ovr_set  | (ovr_q  & ~rd_stat);
            irq     <= ~empty;
            if (ce && r) begin
                if (addr)        out_data <= status;
                else if (!empty) out_data <= mem_q[rd_ptr_q];
                else             out_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port with CLKS_PER_BIT=16 and a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_port;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       ce;
    logic       r;
    logic       addr;
    logic [7:0] out_data;
    logic       irq;

    int total = 0;
    int bad   = 0;

    uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .ce      (ce),
        .r       (r),
        .addr    (addr),
        .out_data(out_data),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Caller must be at a falling clock edge; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic read_reg(input logic a, output logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; r = 1'b1; addr = a;
        @(negedge clk);
        ce = 1'b0; r = 1'b0;
        d = out_data;
    endtask

    task automatic wait_irq(input int maxc);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("irq_rise", {7'b0, irq}, 8'h01);
    endtask

    logic [7:0] d;
    logic [7:0] exp_bytes [5];

    initial begin
        rst_n = 1'b0; rx = 1'b1; ce = 1'b0; r = 1'b0; addr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;
        read_reg(1'b1, d); chk("rst_status", d, 8'h00);

        // 1: single byte
        @(negedge clk);
        send_frame(8'hA5, 1'b1);
        wait_irq(50);
        read_reg(1'b1, d); chk("t1_status", d, 8'h01);
        read_reg(1'b0, d); chk("t1_data", d, 8'hA5);
        read_reg(1'b1, d); chk("t1_status_empty", d, 8'h00);
        chk("t1_irq_fall", {7'b0, irq}, 8'h00);

        // 2: overrun on the fifth byte
        @(negedge clk);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        read_reg(1'b1, d); chk("t2_status", d, 8'h07);
        for (int i = 1; i <= 4; i++) begin
            read_reg(1'b0, d); chk("t2_data", d, 8'(i));
        end
        read_reg(1'b0, d); chk("t2_data_empty", d, 8'h00);
        read_reg(1'b1, d); chk("t2_status_clr", d, 8'h00);

        // 3: start-bit glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t3_irq", {7'b0, irq}, 8'h00);
        read_reg(1'b1, d); chk("t3_status", d, 8'h00);

        // 4: framing error, break, then a clean byte
        @(negedge clk);
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        read_reg(1'b1, d); chk("t4_status", d, 8'h09);
        read_reg(1'b0, d); chk("t4_data", d, 8'h55);
        read_reg(1'b0, d); chk("t4_data_empty", d, 8'h00);
        read_reg(1'b1, d); chk("t4_status_clr", d, 8'h00);

        // 5: pop on the exact push cycle into a full FIFO
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h66;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_frame(exp_bytes[i], 1'b1);
        repeat (4) @(negedge clk);
        fork
            send_frame(exp_bytes[4], 1'b1);
            begin
                // Stop-bit sample lands on the 155th rising edge after rx falls.
                repeat (154) @(negedge clk);
                ce = 1'b1; r = 1'b1; addr = 1'b0;
                @(negedge clk);
                ce = 1'b0; r = 1'b0;
                chk("t5_pop_on_push", out_data, 8'h11);
            end
        join
        repeat (4) @(negedge clk);
        read_reg(1'b1, d); chk("t5_status", d, 8'h03);
        for (int i = 1; i < 5; i++) begin
            read_reg(1'b0, d); chk("t5_data", d, exp_bytes[i]);
        end
        read_reg(1'b0, d); chk("t5_data_empty", d, 8'h00);

        // 6: reset in the middle of a frame
        @(negedge clk);
        send_frame(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        read_reg(1'b1, d); chk("t6_status_pre", d, 8'h01);
        @(negedge clk);
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (80) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("t6_rst_out_data", out_data, 8'h00);
                chk("t6_rst_irq", {7'b0, irq}, 8'h00);
                repeat (90) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        read_reg(1'b1, d); chk("t6_status_post", d, 8'h00);
        @(negedge clk);
        send_frame(8'h81, 1'b1);
        wait_irq(50);
        read_reg(1'b0, d); chk("t6_data", d, 8'h81);
        read_reg(1'b1, d); chk("t6_status_end", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
